// File: rtl/wb_trace_buffer_pkg.sv
// rtl/wb_trace_buffer_pkg.sv - shared widths, trace entry type and PC helper for the writeback trace buffer
package wb_trace_buffer_pkg;

    localparam int TRACE_PC_W   = 32;
    localparam int TRACE_RD_W   = 5;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_W      = TRACE_PC_W + TRACE_RD_W + TRACE_DATA_W;

    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [TRACE_RD_W-1:0]   rd;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

    // Writeback only carries PC+4; recover the retiring PC with 32-bit wrap.
    function automatic logic [TRACE_PC_W-1:0] pc_from_pc4(input logic [TRACE_PC_W-1:0] pc4);
        return pc4 - TRACE_PC_W'(4);
    endfunction

endpackage

// File: rtl/wb_trace_buffer_fifo.sv
// rtl/wb_trace_buffer_fifo.sv - sync_fifo_fwft: parameterised first-word fall-through FIFO
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == (AW+1)'(DEPTH));
    assign w_empty   = (w_count == '0);
    assign w_do_pop  = i_pop & ~w_empty & ~i_clr;
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = w_count;

endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - wb_trace_buffer: records writeback register writes into a drainable trace FIFO
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int SKIP_X0 = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic                      RegWriteW,
    input  logic [TRACE_RD_W-1:0]     RDW,
    input  logic [TRACE_DATA_W-1:0]   ResultW,
    input  logic [TRACE_PC_W-1:0]     PCPlus4W,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [TRACE_PC_W-1:0]     trace_pc,
    output logic [TRACE_RD_W-1:0]     trace_rd,
    output logic [TRACE_DATA_W-1:0]   trace_data,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      overflow,
    output logic [CNT_W-1:0]          event_count,
    output logic [CNT_W-1:0]          drop_count
);

    logic               w_skip;
    logic               w_event;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    trace_entry_t       w_in_entry;
    trace_entry_t       w_head;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_event_count;
    logic [CNT_W-1:0]   r_drop_count;

    assign w_skip  = (SKIP_X0 != 0) && (RDW == '0);
    assign w_event = en_i & RegWriteW & ~w_skip;
    assign w_pop   = ~w_empty & trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign w_drop  = w_event & w_full & ~w_pop & ~clr_i;

    assign w_in_entry.pc   = pc_from_pc4(PCPlus4W);
    assign w_in_entry.rd   = RDW;
    assign w_in_entry.data = ResultW;

    sync_fifo_fwft #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr_i),
        .i_push  (w_event),
        .i_din   (w_in_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fill_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow    <= 1'b0;
            r_event_count <= '0;
            r_drop_count  <= '0;
        end else if (clr_i) begin
            r_overflow    <= 1'b0;
            r_event_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_event && (r_event_count != '1)) r_event_count <= r_event_count + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign trace_valid = ~w_empty;
    assign trace_pc    = w_head.pc;
    assign trace_rd    = w_head.rd;
    assign trace_data  = w_head.data;
    assign overflow    = r_overflow;
    assign event_count = r_event_count;
    assign drop_count  = r_drop_count;

endmodule
